frame_header_parser: RTL and testbench
======================================

# frame_header_parser

Parametrised successor to the single-byte ICE frame header decoder. Consumes a framed byte stream, records the event ID and a 1..N-byte big-endian length field, and flags empty and fragment packets. Adds what the old decoder lacked: payload pass-through with ready backpressure, a payload counter and last marker, length checking (short, long, truncated header), and an end-of-frame pulse. Sits between the frame receiver and the per-EID payload consumers.

## Interface
- DATA_W, 8, width of one stream word and of the EID field
- LEN_WORDS, 1, number of stream words in the length field (1..4); LEN_W = LEN_WORDS*DATA_W
- CHECK_LEN, 1, 1 = set len_error on short/long payload; 0 = only truncated headers set it

- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_frame_data  in  DATA_W  stream word
- in_frame_data_valid  in  1  in_frame_data valid this cycle
- in_frame_valid  in  1  high for the whole frame
- frame_data_latch  out  1  comb; current word (or frame start) consumed this cycle
- header_eid  out  DATA_W  recorded event ID
- header_len  out  LEN_W  recorded length field
- header_done  out  1  header complete; held until header_done_clear
- header_done_clear  in  1  clears header_done
- packet_is_empty  out  1  header_len == 0
- is_fragment  out  1  header_len == all ones
- payload_data  out  DATA_W  comb copy of in_frame_data
- payload_valid  out  1  comb; payload word offered
- payload_ready  in  1  consumer accepts payload word
- payload_last  out  1  comb; offered word is final declared payload word (never for fragments)
- payload_count  out  LEN_W  payload words transferred this frame
- len_error  out  1  frame length fault; sticky until next frame start
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- Reset: state IDLE; all registered outputs 0 (header_eid, header_len, header_done, packet_is_empty, is_fragment, payload_count, len_error, frame_done); len byte index 0.
- IDLE: frame_data_latch = in_frame_valid; on in_frame_valid -> EID, clear len_error.
- EID: on in_frame_data_valid: latch header_eid, frame_data_latch = 1 -> LEN.
- LEN: each valid word shifts into length register MSB-first, frame_data_latch = 1. On word LEN_WORDS: header_len, packet_is_empty, is_fragment load from final value; header_done <= 1; payload_count <= 0; -> DRAIN if length 0, else PAYLOAD.
- in_frame_valid low in EID or LEN: len_error <= 1, frame_done pulse, -> IDLE; header_done not set.
- PAYLOAD: payload_valid = in_frame_data_valid & in_frame_valid; frame_data_latch = payload_valid & payload_ready (transfer). Each transfer increments payload_count (fragment: saturates at all ones). Non-fragment: payload_last = payload_valid & (payload_count == header_len-1); transfer with last -> DRAIN.
- PAYLOAD, in_frame_valid low: non-fragment -> len_error <= CHECK_LEN (short); fragment -> no error; frame_done pulse, -> IDLE.
- DRAIN: frame_data_latch = in_frame_data_valid (extra words discarded, never offered); any extra word with CHECK_LEN=1 sets len_error (long). in_frame_valid low: frame_done pulse, -> IDLE.
- header_done set and header_done_clear in same cycle: set wins.
- header_done still high when next header completes: stays high, fields overwritten.

## Timing
- Outputs marked comb are combinational from inputs and state; others registered.
- header_done, header_eid, header_len, flags visible the cycle after the last length word is consumed.
- First payload word may be offered that same cycle; zero-bubble throughput with payload_ready high.
- payload_count updates the cycle after each transfer.
- frame_done asserts the cycle after in_frame_valid is sampled low in EID/LEN/PAYLOAD/DRAIN; state is IDLE that cycle, so a new frame may start then.
- len_error readable with frame_done; cleared on the IDLE->EID transition.
- rst_n low mid-frame: immediate return to reset values; the rest of the interrupted frame is treated as new frame start only if in_frame_valid is still high after release.

## Test plan
- DATA_W=8, LEN_WORDS=1: frame EID=0x42, LEN=0x03, payload A1 A2 A3, ready high -> header_eid=0x42, header_len=3, header_done, payload_last on A3, payload_count=3, frame_done, len_error=0.
- LEN=0x00, no payload -> packet_is_empty=1, payload_valid never high, DRAIN, frame_done, len_error=0; LEN=0xFF with 300 words -> is_fragment=1, payload_last never, payload_count saturates 0xFF, no error.
- LEN=0x04, frame ends after 2 words -> len_error=1, payload_count=2; LEN=0x02 with 4 words -> 2 offered, 2 discarded, len_error=1; repeat with CHECK_LEN=0 -> len_error=0.
- LEN_WORDS=2, length words 0x01 0x02 -> header_len=0x0102, 258 words transferred, payload_last on 258th; payload_ready toggled every other cycle -> no word lost or duplicated, frame_data_latch only on transfers.
- header_done_clear same cycle as header completion -> header_done=1; frame ends after EID only -> len_error=1, header_done stays 0.
- rst_n asserted mid-payload -> all outputs 0 asynchronously, state IDLE; next frame parses cleanly.

Source files
------------

// File: rtl/frame_header_parser.sv
// Parses framed streams: EID word, LEN_WORDS big-endian length words, then payload pass-through.
// Latency: header fields registered one cycle after last length word; payload is combinational pass-through.
// Backpressure: payload words stall on payload_ready low; header and drain words are always accepted.
module frame_header_parser #(
   parameter int DATA_W    = 8,
   parameter int LEN_WORDS = 1,
   parameter int CHECK_LEN = 1,
   localparam int LEN_W    = LEN_WORDS * DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_frame_data,
   input  logic              in_frame_data_valid,
   input  logic              in_frame_valid,
   output logic              frame_data_latch,
   output logic [DATA_W-1:0] header_eid,
   output logic [LEN_W-1:0]  header_len,
   output logic              header_done,
   input  logic              header_done_clear,
   output logic              packet_is_empty,
   output logic              is_fragment,
   output logic [DATA_W-1:0] payload_data,
   output logic              payload_valid,
   input  logic              payload_ready,
   output logic              payload_last,
   output logic [LEN_W-1:0]  payload_count,
   output logic              len_error,
   output logic              frame_done
);

   typedef enum logic [2:0] {S_IDLE, S_EID, S_LEN, S_PAYLOAD, S_DRAIN} state_t;

   localparam logic [1:0] LAST_IDX = 2'(LEN_WORDS - 1);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   eid_q, eid_d;
   logic [LEN_W-1:0]    len_shift_q, len_shift_d;
   logic [1:0]          len_idx_q, len_idx_d;
   logic [LEN_W-1:0]    hlen_q, hlen_d;
   logic                hdone_q, hdone_d;
   logic                empty_q, empty_d;
   logic                frag_q, frag_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                lerr_q, lerr_d;
   logic                fdone_q, fdone_d;
   logic [LEN_W-1:0]    len_next;
   logic                is_last;

   // Length accumulates MSB-first: every new word pushes the previous ones up.
   assign len_next = (len_shift_q << DATA_W) | LEN_W'(in_frame_data);

   // Next-state, registered-field updates and combinational stream handshakes.
   always_comb begin
      state_d          = state_q;
      eid_d            = eid_q;
      len_shift_d      = len_shift_q;
      len_idx_d        = len_idx_q;
      hlen_d           = hlen_q;
      hdone_d          = hdone_q & ~header_done_clear;
      empty_d          = empty_q;
      frag_d           = frag_q;
      cnt_d            = cnt_q;
      lerr_d           = lerr_q;
      fdone_d          = 1'b0;
      frame_data_latch = 1'b0;
      payload_valid    = 1'b0;
      payload_last     = 1'b0;
      is_last          = 1'b0;
      case (state_q)
         S_IDLE: begin
            frame_data_latch = in_frame_valid;
            if (in_frame_valid) begin
               state_d     = S_EID;
               lerr_d      = 1'b0;
               len_idx_d   = 2'd0;
               len_shift_d = '0;
            end
         end
         S_EID: begin
            if (!in_frame_valid) begin
               lerr_d  = 1'b1;
               fdone_d = 1'b1;
               state_d = S_IDLE;
            end else if (in_frame_data_valid) begin
               frame_data_latch = 1'b1;
               eid_d            = in_frame_data;
               state_d          = S_LEN;
            end
         end
         S_LEN: begin
            if (!in_frame_valid) begin
               lerr_d  = 1'b1;
               fdone_d = 1'b1;
               state_d = S_IDLE;
            end else if (in_frame_data_valid) begin
               frame_data_latch = 1'b1;
               len_shift_d      = len_next;
               len_idx_d        = len_idx_q + 2'd1;
               if (len_idx_q == LAST_IDX) begin
                  // Setting header_done here overrides a same-cycle clear.
                  hlen_d  = len_next;
                  empty_d = (len_next == '0);
                  frag_d  = &len_next;
                  hdone_d = 1'b1;
                  cnt_d   = '0;
                  state_d = (len_next == '0) ? S_DRAIN : S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            payload_valid = in_frame_data_valid & in_frame_valid;
            if (!in_frame_valid) begin
               // Fragments have no declared end, so an early stop is not a fault.
               if (!frag_q && CHECK_LEN != 0) lerr_d = 1'b1;
               fdone_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               is_last          = ~frag_q & (cnt_q == hlen_q - LEN_W'(1));
               payload_last     = payload_valid & is_last;
               frame_data_latch = payload_valid & payload_ready;
               if (frame_data_latch) begin
                  cnt_d = (frag_q && (&cnt_q)) ? cnt_q : cnt_q + LEN_W'(1);
                  if (is_last) state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            frame_data_latch = in_frame_data_valid;
            if (!in_frame_valid) begin
               fdone_d = 1'b1;
               state_d = S_IDLE;
            end else if (in_frame_data_valid && CHECK_LEN != 0) begin
               lerr_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset returns everything to zero immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         eid_q       <= '0;
         len_shift_q <= '0;
         len_idx_q   <= 2'd0;
         hlen_q      <= '0;
         hdone_q     <= 1'b0;
         empty_q     <= 1'b0;
         frag_q      <= 1'b0;
         cnt_q       <= '0;
         lerr_q      <= 1'b0;
         fdone_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         eid_q       <= eid_d;
         len_shift_q <= len_shift_d;
         len_idx_q   <= len_idx_d;
         hlen_q      <= hlen_d;
         hdone_q     <= hdone_d;
         empty_q     <= empty_d;
         frag_q      <= frag_d;
         cnt_q       <= cnt_d;
         lerr_q      <= lerr_d;
         fdone_q     <= fdone_d;
      end
   end

   assign header_eid      = eid_q;
   assign header_len      = hlen_q;
   assign header_done     = hdone_q;
   assign packet_is_empty = empty_q;
   assign is_fragment     = frag_q;
   assign payload_data    = in_frame_data;
   assign payload_count   = cnt_q;
   assign len_error       = lerr_q;
   assign frame_done      = fdone_q;

endmodule

// File: tb/tb_frame_header_parser.sv
// Bench for frame_header_parser: three instances (1-word checked, 1-word unchecked, 2-word checked length).
// Frames are driven word by word; the instance under test is selected by cur.
// Expectations come from a frame-level model of header, payload and length rules.
module tb_frame_header_parser;

   logic clk = 1'b0;
   logic rst_n;
   logic [7:0] din;
   logic dv, fv, hclr, prdy;

   logic       fdl[3];
   logic [7:0] heid[3];
   logic [7:0] hlen0, hlen1;
   logic [15:0] hlen2;
   logic       hdone[3], empty[3], frag[3];
   logic [7:0] pdat[3];
   logic       pv[3], plast[3];
   logic [7:0] cnt0, cnt1;
   logic [15:0] cnt2;
   logic       lerr[3], fdone[3];

   int cur;
   logic [15:0] m_len, m_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] frame_w[$];
   logic [7:0] got_d[$];
   logic       got_l[$];

   always #5 clk = ~clk;

   always_comb begin
      case (cur)
         0: begin m_len = {8'h00, hlen0}; m_cnt = {8'h00, cnt0}; end
         1: begin m_len = {8'h00, hlen1}; m_cnt = {8'h00, cnt1}; end
         default: begin m_len = hlen2; m_cnt = cnt2; end
      endcase
   end

   frame_header_parser #(.DATA_W(8), .LEN_WORDS(1), .CHECK_LEN(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_frame_data(din), .in_frame_data_valid(dv),
      .in_frame_valid(fv), .frame_data_latch(fdl[0]), .header_eid(heid[0]),
      .header_len(hlen0), .header_done(hdone[0]), .header_done_clear(hclr),
      .packet_is_empty(empty[0]), .is_fragment(frag[0]), .payload_data(pdat[0]),
      .payload_valid(pv[0]), .payload_ready(prdy), .payload_last(plast[0]),
      .payload_count(cnt0), .len_error(lerr[0]), .frame_done(fdone[0]));

   frame_header_parser #(.DATA_W(8), .LEN_WORDS(1), .CHECK_LEN(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_frame_data(din), .in_frame_data_valid(dv),
      .in_frame_valid(fv), .frame_data_latch(fdl[1]), .header_eid(heid[1]),
      .header_len(hlen1), .header_done(hdone[1]), .header_done_clear(hclr),
      .packet_is_empty(empty[1]), .is_fragment(frag[1]), .payload_data(pdat[1]),
      .payload_valid(pv[1]), .payload_ready(prdy), .payload_last(plast[1]),
      .payload_count(cnt1), .len_error(lerr[1]), .frame_done(fdone[1]));

   frame_header_parser #(.DATA_W(8), .LEN_WORDS(2), .CHECK_LEN(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_frame_data(din), .in_frame_data_valid(dv),
      .in_frame_valid(fv), .frame_data_latch(fdl[2]), .header_eid(heid[2]),
      .header_len(hlen2), .header_done(hdone[2]), .header_done_clear(hclr),
      .packet_is_empty(empty[2]), .is_fragment(frag[2]), .payload_data(pdat[2]),
      .payload_valid(pv[2]), .payload_ready(prdy), .payload_last(plast[2]),
      .payload_count(cnt2), .len_error(lerr[2]), .frame_done(fdone[2]));

   // Frame image: EID, length words MSB-first for the current instance, then npay random bytes.
   task automatic build(input int eid, input int lenv, input int npay);
      frame_w.delete();
      frame_w.push_back(8'(eid));
      if (cur == 2) frame_w.push_back(8'(lenv >> 8));
      frame_w.push_back(8'(lenv));
      for (int i = 0; i < npay; i++) frame_w.push_back(8'($urandom));
   endtask

   // Drives frame_w (up to stop_at words); when the whole frame is sent, ends it and checks it.
   task automatic run_frame(input string tag, input int rmode, input bit clr_at_hdr, input int stop_at);
      int idx, cyc, stalls, badlatch, n, lw, lenv, npay, maxv, offered, ecnt;
      bit r, ck, hdr, isfrag, eerr;
      idx = 0; cyc = 0; stalls = 0; badlatch = 0;
      n = frame_w.size();
      lw = (cur == 2) ? 2 : 1;
      got_d.delete(); got_l.delete();
      @(negedge clk);
      fv = 1'b1; dv = 1'b0; hclr = 1'b1; prdy = 1'b0;
      while (idx < n && idx < stop_at && cyc < 4000) begin
         @(negedge clk);
         hclr = (clr_at_hdr && idx == lw) ? 1'b1 : 1'b0;
         din = frame_w[idx]; dv = 1'b1; fv = 1'b1;
         if (rmode == 0) r = 1'b1;
         else if (rmode == 1) r = (cyc % 2 == 0);
         else r = 1'($urandom_range(0, 1));
         prdy = r;
         #1;
         if (pv[cur]) begin
            if (fdl[cur] !== r) badlatch++;
            if (r) begin got_d.push_back(pdat[cur]); got_l.push_back(plast[cur]); end
         end
         if (r && fdl[cur] !== 1'b1) stalls++;
         if (fdl[cur] === 1'b1) idx++;
         cyc++;
      end
      if (cyc >= 4000) begin
         n_checks++; n_fail++;
         $display("FAIL %s timeout: consumed %0d of %0d words", tag, idx, n);
      end
      if (stop_at < n) return;
      @(negedge clk);
      fv = 1'b0; dv = 1'b0; prdy = 1'b0; hclr = 1'b0; din = 8'h00;
      @(negedge clk);

      // Frame-level reference
      ck = (cur != 1);
      maxv = (lw == 2) ? 65535 : 255;
      hdr = (n >= 1 + lw);
      lenv = 0;
      if (hdr) for (int i = 1; i <= lw; i++) lenv = lenv * 256 + int'(frame_w[i]);
      npay = hdr ? n - 1 - lw : 0;
      isfrag = hdr && (lenv == maxv);
      offered = isfrag ? npay : ((npay < lenv) ? npay : lenv);
      ecnt = isfrag ? ((npay < maxv) ? npay : maxv) : offered;
      eerr = !hdr ? 1'b1 : (isfrag ? 1'b0 : (ck ? (npay != lenv) : 1'b0));

      n_checks++;
      if (fdone[cur] !== 1'b1) begin n_fail++; $display("FAIL %s frame_done: got %b want 1", tag, fdone[cur]); end
      n_checks++;
      if (lerr[cur] !== eerr) begin n_fail++; $display("FAIL %s len_error: got %b want %b", tag, lerr[cur], eerr); end
      n_checks++;
      if (hdone[cur] !== hdr) begin n_fail++; $display("FAIL %s header_done: got %b want %b", tag, hdone[cur], hdr); end
      n_checks++;
      if (stalls != 0) begin n_fail++; $display("FAIL %s stall: got %0d stalled cycles want 0", tag, stalls); end
      n_checks++;
      if (badlatch != 0) begin n_fail++; $display("FAIL %s latch_vs_ready: got %0d bad cycles want 0", tag, badlatch); end
      n_checks++;
      if (got_d.size() != offered) begin n_fail++; $display("FAIL %s offered: got %0d words want %0d", tag, got_d.size(), offered); end
      for (int i = 0; i < got_d.size() && i < offered; i++) begin
         n_checks++;
         if (got_d[i] !== frame_w[1 + lw + i] || got_l[i] !== (!isfrag && i == lenv - 1)) begin
            n_fail++;
            $display("FAIL %s word%0d: got %h last %b want %h last %b", tag, i, got_d[i], got_l[i],
                     frame_w[1 + lw + i], (!isfrag && i == lenv - 1));
         end
      end
      if (hdr) begin
         n_checks++;
         if (heid[cur] !== frame_w[0]) begin n_fail++; $display("FAIL %s header_eid: got %h want %h", tag, heid[cur], frame_w[0]); end
         n_checks++;
         if (m_len !== 16'(lenv)) begin n_fail++; $display("FAIL %s header_len: got %h want %h", tag, m_len, 16'(lenv)); end
         n_checks++;
         if (empty[cur] !== (lenv == 0) || frag[cur] !== isfrag) begin
            n_fail++;
            $display("FAIL %s flags: got empty %b frag %b want %b %b", tag, empty[cur], frag[cur], (lenv == 0), isfrag);
         end
         n_checks++;
         if (m_cnt !== 16'(ecnt)) begin n_fail++; $display("FAIL %s payload_count: got %0d want %0d", tag, m_cnt, ecnt); end
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         cur = s;
         #1;
         n_checks++;
         if ({hdone[s], empty[s], frag[s], lerr[s], fdone[s], pv[s], fdl[s]} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags dut%0d: got %b want 0000000", s,
                     {hdone[s], empty[s], frag[s], lerr[s], fdone[s], pv[s], fdl[s]});
         end
         n_checks++;
         if (heid[s] !== 8'h00 || m_len !== 16'h0 || m_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_fields dut%0d: got eid %h len %h cnt %h want 0", s, heid[s], m_len, m_cnt);
         end
      end
   endtask

   task automatic test_basic();
      cur = 0;
      frame_w = '{8'h42, 8'h03, 8'hA1, 8'hA2, 8'hA3};
      run_frame("basic", 0, 1'b0, 1 << 30);
   endtask

   task automatic test_empty();
      cur = 0; build(8'h11, 0, 0); run_frame("empty", 0, 1'b0, 1 << 30);
      cur = 0; build(8'h12, 0, 2); run_frame("empty_extra", 0, 1'b0, 1 << 30);
   endtask

   task automatic test_fragment();
      cur = 0; build(8'h55, 255, 300); run_frame("fragment", 0, 1'b0, 1 << 30);
   endtask

   task automatic test_length_faults();
      cur = 0; build(8'h21, 4, 2); run_frame("short", 2, 1'b0, 1 << 30);
      cur = 0; build(8'h22, 2, 4); run_frame("long", 2, 1'b0, 1 << 30);
      cur = 1; build(8'h23, 4, 2); run_frame("short_nocheck", 2, 1'b0, 1 << 30);
      cur = 1; build(8'h24, 2, 4); run_frame("long_nocheck", 2, 1'b0, 1 << 30);
   endtask

   task automatic test_wide_len();
      cur = 2; build(8'h77, 16'h0102, 258); run_frame("wide_toggle", 1, 1'b0, 1 << 30);
   endtask

   task automatic test_header_clear();
      cur = 0; build(8'h31, 3, 3); run_frame("hdr_clear_same_cycle", 2, 1'b1, 1 << 30);
      cur = 0; build(8'h32, 0, 0); frame_w.pop_back(); run_frame("trunc_eid_only", 0, 1'b0, 1 << 30);
      cur = 2; build(8'h33, 5, 0); frame_w.pop_back(); run_frame("trunc_len2", 0, 1'b0, 1 << 30);
   endtask

   task automatic test_reset_mid();
      cur = 0;
      build(8'h61, 5, 5);
      run_frame("mid_reset_part", 0, 1'b0, 4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({hdone[0], lerr[0], fdone[0], pv[0], empty[0], frag[0]} !== 6'b0) begin
         n_fail++;
         $display("FAIL mid_reset_flags: got %b want 000000", {hdone[0], lerr[0], fdone[0], pv[0], empty[0], frag[0]});
      end
      n_checks++;
      if (heid[0] !== 8'h00 || m_len !== 16'h0 || m_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL mid_reset_fields: got eid %h len %h cnt %h want 0", heid[0], m_len, m_cnt);
      end
      fv = 1'b0; dv = 1'b0; prdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      build(8'h62, 3, 3);
      run_frame("after_reset", 0, 1'b0, 1 << 30);
   endtask

   task automatic test_random();
      int lenv, npay, lw;
      for (int k = 0; k < 24; k++) begin
         cur = k % 3;
         lw = (cur == 2) ? 2 : 1;
         lenv = $urandom_range(0, 8);
         if ($urandom_range(0, 9) == 0) lenv = (cur == 2) ? 65535 : 255;
         npay = $urandom_range(0, 10);
         build($urandom_range(0, 255), lenv, npay);
         if ($urandom_range(0, 6) == 0)
            while (frame_w.size() > $urandom_range(1, lw)) void'(frame_w.pop_back());
         run_frame($sformatf("random%0d", k), 2, 1'($urandom_range(0, 1)), 1 << 30);
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cur = 0; rst_n = 1'b0;
      din = 8'h00; dv = 1'b0; fv = 1'b0; hclr = 1'b0; prdy = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_basic();
      test_empty();
      test_fragment();
      test_length_faults();
      test_wide_len();
      test_header_clear();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
